// File: rtl/grad_accumulator.sv
// Minibatch gradient averager: sums 2^BATCH_LOG2 element-serial gradient tensors
// per element, then streams the per-element mean (floor) to the update stage.
module grad_accumulator #(
   parameter int DATA_WIDTH = 32,
   parameter int N_ELEM     = 64,
   parameter int BATCH_LOG2 = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_last,
   output logic                         busy,
   output logic                         len_err
);

   localparam int ACC_WIDTH = DATA_WIDTH + BATCH_LOG2;
   localparam int IDX_W     = $clog2(N_ELEM);
   localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(N_ELEM - 1);
   localparam logic [BATCH_LOG2-1:0] LAST_SAMPLE = '1;

   typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]              rd_idx_q, rd_idx_d;
   logic [BATCH_LOG2-1:0]         sample_q, sample_d;
   logic                          len_err_q, len_err_d;
   logic signed [ACC_WIDTH-1:0]   acc_q [N_ELEM];
   logic                          acc_we;
   logic signed [ACC_WIDTH-1:0]   acc_wdata;
   logic                          in_fire, out_fire, wr_last, rd_last;

   function automatic logic signed [ACC_WIDTH-1:0] sign_extend(input logic signed [DATA_WIDTH-1:0] x);
      return {{BATCH_LOG2{x[DATA_WIDTH-1]}}, x};
   endfunction

   // Mean of 2^BATCH_LOG2 DATA_WIDTH-bit values always fits back into DATA_WIDTH.
   function automatic logic signed [DATA_WIDTH-1:0] batch_mean(input logic signed [ACC_WIDTH-1:0] s);
      return DATA_WIDTH'(s >>> BATCH_LOG2);
   endfunction

   always_comb begin
      in_ready  = (state_q == ST_ACCUM);
      out_valid = (state_q == ST_DRAIN);
      busy      = out_valid;
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      wr_last   = (wr_idx_q == LAST_IDX);
      rd_last   = (rd_idx_q == LAST_IDX);
      out_last  = out_valid && rd_last;
      out_data  = out_valid ? batch_mean(acc_q[rd_idx_q]) : '0;
      len_err   = len_err_q;
   end

   always_comb begin
      state_d   = state_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      sample_d  = sample_q;
      len_err_d = len_err_q;
      acc_we    = in_fire;
      // First sample of a batch overwrites, so stale sums never leak forward.
      acc_wdata = (sample_q == '0) ? sign_extend(in_data)
                                   : acc_q[wr_idx_q] + sign_extend(in_data);
      if (in_fire) begin
         if (in_last != wr_last) begin
            len_err_d = 1'b1;
         end
         if (wr_last) begin
            wr_idx_d = '0;
            sample_d = sample_q + 1'b1;
            if (sample_q == LAST_SAMPLE) begin
               state_d = ST_DRAIN;
            end
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end
      if (out_fire) begin
         if (rd_last) begin
            rd_idx_d = '0;
            state_d  = ST_ACCUM;
         end else begin
            rd_idx_d = rd_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ACCUM;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         sample_q  <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         sample_q  <= sample_d;
         len_err_q <= len_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_we) begin
         acc_q[wr_idx_q] <= acc_wdata;
      end
   end

endmodule
